main1_datapath: RTL and testbench

- 32-bit single-bus datapath for the Mini-SRC-style processor. The DUT is instantiated as main1.
- Contains:
  - 16 general registers R0–R15.
  - Registers PC, IR, MAR, MDR, HI, LO, Y, Z (64-bit), InPort, OutPort and the CON flip-flop.
  - The ALU and the select/encode logic.
- The external control unit or testbench drives the per-step control strobes. Memory read data arrives on MDatain.

---
 rtl/main1_datapath_pkg.sv | 41 ++++
 rtl/main1_datapath_if.sv | 31 +++
 rtl/main1_alu.sv | 61 ++++++
 rtl/main1_datapath.sv | 128 ++++++++++++
 tb/tb_main1_datapath.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/main1_datapath_pkg.sv
// Shared definitions for the main1 single-bus datapath: ALU opcodes,
// CON condition codes and IR field positions.
package main1_datapath_pkg;

    typedef enum logic [3:0] {
        ALU_PASS = 4'b0000,
        ALU_ADD  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_SHR  = 4'b0101,
        ALU_SHL  = 4'b0110,
        ALU_ROR  = 4'b0111,
        ALU_ROL  = 4'b1000,
        ALU_INC  = 4'b1001,
        ALU_MUL  = 4'b1010,
        ALU_DIV  = 4'b1011,
        ALU_NEG  = 4'b1100,
        ALU_NOT  = 4'b1101,
        ALU_SHRA = 4'b1110,
        ALU_ZERO = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        COND_ZERO    = 2'b00,
        COND_NONZERO = 2'b01,
        COND_POS     = 2'b10,
        COND_NEG     = 2'b11
    } cond_e;

    localparam int unsigned IR_RA_MSB = 26;
    localparam int unsigned IR_RA_LSB = 23;
    localparam int unsigned IR_RB_MSB = 22;
    localparam int unsigned IR_RB_LSB = 19;
    localparam int unsigned IR_RC_MSB = 18;
    localparam int unsigned IR_RC_LSB = 15;
    localparam int unsigned IR_C_MSB  = 18;
    localparam int unsigned IR_C2_MSB = 20;
    localparam int unsigned IR_C2_LSB = 19;

endpackage

// File: rtl/main1_datapath_if.sv
// Control strobes, data inputs and observable register outputs of the
// main1 datapath; the control unit is the master.
interface main1_datapath_if;

    logic        Rin, Rout, Gra, Grb, Grc, BAout;
    logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin, conIn, outPortin;
    logic        HIout, LOout, PCout, MDRout, ZLowout, ZHighout, InPortout, Cout, conOut;
    logic        MDRread, IncPC;
    logic [3:0]  ALUselect;
    logic [31:0] MDatain, InPortData;
    logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, OutPort_q;
    logic [63:0] Z_q;
    logic        CON;

    modport master (
        output Rin, Rout, Gra, Grb, Grc, BAout,
        output HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin, conIn, outPortin,
        output HIout, LOout, PCout, MDRout, ZLowout, ZHighout, InPortout, Cout, conOut,
        output MDRread, IncPC, ALUselect, MDatain, InPortData,
        input  BusMuxOut, PC_q, IR_q, MAR_q, OutPort_q, Z_q, CON
    );

    modport slave (
        input  Rin, Rout, Gra, Grb, Grc, BAout,
        input  HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin, conIn, outPortin,
        input  HIout, LOout, PCout, MDRout, ZLowout, ZHighout, InPortout, Cout, conOut,
        input  MDRread, IncPC, ALUselect, MDatain, InPortData,
        output BusMuxOut, PC_q, IR_q, MAR_q, OutPort_q, Z_q, CON
    );

endinterface

// File: rtl/main1_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result destined for Z.
module main1_alu
    import main1_datapath_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        inc_pc,
    output logic [63:0] result
);

    logic [4:0]         sh;
    logic [5:0]         sh_inv;
    logic [31:0]        shra_v;
    logic signed [63:0] prod;
    logic signed [32:0] sa, sb, quot, rem;
    logic               unused_div;

    always_comb begin
        sh     = b[4:0];
        sh_inv = 6'd32 - {1'b0, sh};
        shra_v = $unsigned($signed(a) >>> sh);
        prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        // 33-bit signed divide keeps -2^31 / -1 well defined (wraps to 0x80000000)
        sa   = $signed({a[31], a});
        sb   = $signed({b[31], b});
        quot = '0;
        rem  = '0;
        if (b != '0) begin
            quot = sa / sb;
            rem  = sa % sb;
        end

        result = '0;
        if (inc_pc) begin
            result = {32'b0, b + 32'd1};
        end else begin
            case (op)
                ALU_PASS: result = {32'b0, b};
                ALU_ADD:  result = {32'b0, a + b};
                ALU_SUB:  result = {32'b0, a - b};
                ALU_AND:  result = {32'b0, a & b};
                ALU_OR:   result = {32'b0, a | b};
                ALU_SHR:  result = {32'b0, a >> sh};
                ALU_SHL:  result = {32'b0, a << sh};
                ALU_ROR:  result = {32'b0, (a >> sh) | (a << sh_inv)};
                ALU_ROL:  result = {32'b0, (a << sh) | (a >> sh_inv)};
                ALU_INC:  result = {32'b0, b + 32'd1};
                ALU_MUL:  result = prod;
                ALU_DIV:  result = {rem[31:0], quot[31:0]};
                ALU_NEG:  result = {32'b0, 32'd0 - b};
                ALU_NOT:  result = {32'b0, ~b};
                ALU_SHRA: result = {32'b0, shra_v};
                default:  result = '0;
            endcase
        end
    end

    assign unused_div = ^{quot[32], rem[32]};

endmodule

// File: rtl/main1_datapath.sv
// Mini-SRC style 32-bit single-bus datapath: register file, special
// registers, bus multiplexer, CON logic and the ALU instance.
module main1_datapath
    import main1_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    main1_datapath_if.slave dp
);

    logic [WIDTH-1:0]   gpr_q [16];
    logic [WIDTH-1:0]   gpr_d [16];
    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [WIDTH-1:0]   inport_q, inport_d, outport_q, outport_d;
    logic [2*WIDTH-1:0] z_q, z_d, alu_result;
    logic               con_q, con_d, con_test;
    logic [3:0]         reg_sel;
    logic [WIDTH-1:0]   c_ext, bus;

    always_comb begin
        reg_sel = ({4{dp.Gra}} & ir_q[IR_RA_MSB:IR_RA_LSB])
                | ({4{dp.Grb}} & ir_q[IR_RB_MSB:IR_RB_LSB])
                | ({4{dp.Grc}} & ir_q[IR_RC_MSB:IR_RC_LSB]);
        c_ext   = {{(WIDTH-IR_C_MSB-1){ir_q[IR_C_MSB]}}, ir_q[IR_C_MSB:0]};
    end

    always_comb begin
        bus = '0;
        if (dp.Rout)           bus = gpr_q[reg_sel];
        else if (dp.BAout)     bus = (reg_sel == 4'd0) ? '0 : gpr_q[reg_sel];
        else if (dp.HIout)     bus = hi_q;
        else if (dp.LOout)     bus = lo_q;
        else if (dp.ZHighout)  bus = z_q[2*WIDTH-1:WIDTH];
        else if (dp.ZLowout)   bus = z_q[WIDTH-1:0];
        else if (dp.PCout)     bus = pc_q;
        else if (dp.MDRout)    bus = mdr_q;
        else if (dp.InPortout) bus = inport_q;
        else if (dp.Cout)      bus = c_ext;
        else if (dp.conOut)    bus = {{(WIDTH-1){1'b0}}, con_q};
    end

    main1_alu u_alu (
        .a      (y_q),
        .b      (bus),
        .op     (dp.ALUselect),
        .inc_pc (dp.IncPC),
        .result (alu_result)
    );

    always_comb begin
        con_test = 1'b0;
        case (cond_e'(ir_q[IR_C2_MSB:IR_C2_LSB]))
            COND_ZERO:    con_test = (bus == '0);
            COND_NONZERO: con_test = (bus != '0);
            COND_POS:     con_test = ~bus[WIDTH-1];
            COND_NEG:     con_test = bus[WIDTH-1];
            default:      con_test = 1'b0;
        endcase
    end

    always_comb begin
        gpr_d     = gpr_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        y_d       = y_q;
        z_d       = z_q;
        con_d     = con_q;
        outport_d = outport_q;
        inport_d  = dp.InPortData;
        if (dp.Rin)       gpr_d[reg_sel] = bus;
        if (dp.PCin)      pc_d      = bus;
        if (dp.IRin)      ir_d      = bus;
        if (dp.MARin)     mar_d     = bus;
        if (dp.MDRin)     mdr_d     = dp.MDRread ? dp.MDatain : bus;
        if (dp.HIin)      hi_d      = bus;
        if (dp.LOin)      lo_d      = bus;
        if (dp.Yin)       y_d       = bus;
        if (dp.Zin)       z_d       = alu_result;
        if (dp.conIn)     con_d     = con_test;
        if (dp.outPortin) outport_d = bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) gpr_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            con_q     <= 1'b0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            gpr_q     <= gpr_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            y_q       <= y_d;
            z_q       <= z_d;
            con_q     <= con_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
        end
    end

    assign dp.BusMuxOut = bus;
    assign dp.PC_q      = pc_q;
    assign dp.IR_q      = ir_q;
    assign dp.MAR_q     = mar_q;
    assign dp.Z_q       = z_q;
    assign dp.OutPort_q = outport_q;
    assign dp.CON       = con_q;

endmodule

// File: tb/tb_main1_datapath.sv
// Self-checking bench for main1_datapath: reset, fetch/load sequences,
// table-driven ALU sweep through a scoreboard, bus priority and CON.
module tb_main1_datapath;
    import main1_datapath_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    main1_datapath_if dp_if ();

    main1_datapath #(.WIDTH(32)) main1 (
        .clk   (clk),
        .reset (reset),
        .dp    (dp_if)
    );

    typedef struct {
        logic [31:0] y;
        logic [31:0] b;
        logic [3:0]  op;
        logic        inc;
        logic [63:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] busv;
        logic        exp;
    } con_vec_t;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q [$];
    alu_vec_t    alu_vecs [$];
    con_vec_t    con_vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        dp_if.Rin = 0; dp_if.Rout = 0; dp_if.Gra = 0; dp_if.Grb = 0; dp_if.Grc = 0;
        dp_if.BAout = 0; dp_if.HIin = 0; dp_if.LOin = 0; dp_if.PCin = 0; dp_if.IRin = 0;
        dp_if.Yin = 0; dp_if.Zin = 0; dp_if.MARin = 0; dp_if.MDRin = 0; dp_if.conIn = 0;
        dp_if.outPortin = 0; dp_if.HIout = 0; dp_if.LOout = 0; dp_if.PCout = 0;
        dp_if.MDRout = 0; dp_if.ZLowout = 0; dp_if.ZHighout = 0; dp_if.InPortout = 0;
        dp_if.Cout = 0; dp_if.conOut = 0; dp_if.MDRread = 0; dp_if.IncPC = 0;
        dp_if.ALUselect = 4'b0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latch v into InPort, then leave InPortout driving it for the next edge.
    task automatic put_inport(input logic [31:0] v);
        clear_ctl();
        dp_if.InPortData = v;
        step();
        dp_if.InPortout = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_vecs.push_back('{32'h00000001, 32'h12345678, ALU_PASS, 1'b0, 64'h0000_0000_1234_5678});
        alu_vecs.push_back('{32'h80000022, 32'h00000003, ALU_ADD,  1'b0, 64'h0000_0000_8000_0025});
        alu_vecs.push_back('{32'hFFFFFFFF, 32'h00000002, ALU_ADD,  1'b0, 64'h0000_0000_0000_0001});
        alu_vecs.push_back('{32'h00000005, 32'h00000007, ALU_SUB,  1'b0, 64'h0000_0000_FFFF_FFFE});
        alu_vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, ALU_AND,  1'b0, 64'h0000_0000_F000_F000});
        alu_vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, ALU_OR,   1'b0, 64'h0000_0000_FFF0_FFF0});
        alu_vecs.push_back('{32'h80000022, 32'h00000003, ALU_SHR,  1'b0, 64'h0000_0000_1000_0004});
        alu_vecs.push_back('{32'h80000022, 32'h00000003, ALU_SHL,  1'b0, 64'h0000_0000_0000_0110});
        alu_vecs.push_back('{32'h00000001, 32'h0000001F, ALU_SHL,  1'b0, 64'h0000_0000_8000_0000});
        alu_vecs.push_back('{32'h80000022, 32'h00000003, ALU_ROR,  1'b0, 64'h0000_0000_5000_0004});
        alu_vecs.push_back('{32'h80000022, 32'h00000003, ALU_ROL,  1'b0, 64'h0000_0000_0000_0114});
        alu_vecs.push_back('{32'h80000022, 32'h00000020, ALU_ROR,  1'b0, 64'h0000_0000_8000_0022});
        alu_vecs.push_back('{32'h00000000, 32'hFFFFFFFF, ALU_INC,  1'b0, 64'h0000_0000_0000_0000});
        alu_vecs.push_back('{32'hFFFFFFFF, 32'h00000002, ALU_MUL,  1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        alu_vecs.push_back('{32'h00000022, 32'h00000003, ALU_DIV,  1'b0, 64'h0000_0001_0000_000B});
        alu_vecs.push_back('{32'hFFFFFFF9, 32'h00000002, ALU_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        alu_vecs.push_back('{32'h00000022, 32'h00000000, ALU_DIV,  1'b0, 64'h0000_0000_0000_0000});
        alu_vecs.push_back('{32'h00000000, 32'h00000001, ALU_NEG,  1'b0, 64'h0000_0000_FFFF_FFFF});
        alu_vecs.push_back('{32'h00000000, 32'h0F0F0F0F, ALU_NOT,  1'b0, 64'h0000_0000_F0F0_F0F0});
        alu_vecs.push_back('{32'h80000022, 32'h00000003, ALU_SHRA, 1'b0, 64'h0000_0000_F000_0004});
        alu_vecs.push_back('{32'h0000FFFF, 32'h0000FFFF, ALU_ZERO, 1'b0, 64'h0000_0000_0000_0000});
        alu_vecs.push_back('{32'h00000005, 32'h00000009, ALU_MUL,  1'b1, 64'h0000_0000_0000_000A});

        con_vecs.push_back('{32'h00180000, 32'h80000000, 1'b1});
        con_vecs.push_back('{32'h00000000, 32'h00000007, 1'b0});
        con_vecs.push_back('{32'h00000000, 32'h00000000, 1'b1});
        con_vecs.push_back('{32'h00080000, 32'h00000000, 1'b0});
        con_vecs.push_back('{32'h00100000, 32'h80000000, 1'b0});
        con_vecs.push_back('{32'h00100000, 32'h00000007, 1'b1});

        // Reset with every enable and driver high
        clear_ctl();
        dp_if.MDatain = 32'hFFFF_FFFF;
        dp_if.InPortData = 32'h1234_5678;
        reset = 1'b1;
        dp_if.Rin = 1; dp_if.Rout = 1; dp_if.HIin = 1; dp_if.LOin = 1; dp_if.PCin = 1;
        dp_if.IRin = 1; dp_if.Yin = 1; dp_if.Zin = 1; dp_if.MARin = 1; dp_if.MDRin = 1;
        dp_if.conIn = 1; dp_if.outPortin = 1; dp_if.MDRread = 1; dp_if.IncPC = 1;
        dp_if.HIout = 1; dp_if.PCout = 1; dp_if.conOut = 1; dp_if.Cout = 1;
        step();
        check("reset_bus", {32'b0, dp_if.BusMuxOut}, 64'h0);
        check("reset_pc",  {32'b0, dp_if.PC_q}, 64'h0);
        check("reset_z",   dp_if.Z_q, 64'h0);
        check("reset_con", {63'b0, dp_if.CON}, 64'h0);
        check("reset_ir",  {32'b0, dp_if.IR_q}, 64'h0);
        check("reset_outport", {32'b0, dp_if.OutPort_q}, 64'h0);
        reset = 1'b0;
        clear_ctl();
        dp_if.InPortData = 32'h0;
        step();

        // Instruction fetch
        dp_if.MDatain = 32'h0080_0055;
        dp_if.PCout = 1; dp_if.MARin = 1; dp_if.IncPC = 1; dp_if.Zin = 1;
        step(); clear_ctl();
        dp_if.ZLowout = 1; dp_if.PCin = 1; dp_if.MDRread = 1; dp_if.MDRin = 1;
        step(); clear_ctl();
        dp_if.MDRout = 1; dp_if.IRin = 1;
        step(); clear_ctl();
        check("fetch_mar", {32'b0, dp_if.MAR_q}, 64'h0);
        check("fetch_pc",  {32'b0, dp_if.PC_q}, 64'h1);
        check("fetch_ir",  {32'b0, dp_if.IR_q}, 64'h0080_0055);

        // ld R1,$85
        dp_if.MDatain = 32'hCAFE_BABE;
        dp_if.Grb = 1; dp_if.BAout = 1; dp_if.Yin = 1;
        step(); clear_ctl();
        dp_if.Cout = 1; dp_if.ALUselect = ALU_ADD; dp_if.Zin = 1;
        step(); clear_ctl();
        check("ld_z_addr", dp_if.Z_q, 64'h55);
        dp_if.ZLowout = 1; dp_if.MARin = 1;
        step(); clear_ctl();
        check("ld_mar", {32'b0, dp_if.MAR_q}, 64'h55);
        dp_if.MDRread = 1; dp_if.MDRin = 1;
        step(); clear_ctl();
        dp_if.MDRout = 1; dp_if.Gra = 1; dp_if.Rin = 1;
        step(); clear_ctl();
        dp_if.Gra = 1; dp_if.Rout = 1;
        #1;
        check("ld_r1", {32'b0, dp_if.BusMuxOut}, 64'hCAFE_BABE);
        clear_ctl();

        // ALU sweep through the scoreboard
        foreach (alu_vecs[i]) begin
            put_inport(alu_vecs[i].y);
            dp_if.Yin = 1;
            dp_if.InPortData = alu_vecs[i].b;
            step(); clear_ctl();
            dp_if.InPortout = 1; dp_if.ALUselect = alu_vecs[i].op;
            dp_if.IncPC = alu_vecs[i].inc; dp_if.Zin = 1;
            sb_q.push_back(alu_vecs[i].exp);
            step(); clear_ctl();
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL alu_sb_empty: got no entry expected one (vector %0d)", i);
            end else begin
                check($sformatf("alu_%0d_op%0h", i, alu_vecs[i].op), dp_if.Z_q, sb_q.pop_front());
            end
        end

        // Bus priority and R0 handling
        put_inport(32'h0001_0000); dp_if.IRin = 1; step();
        put_inport(32'h5);         dp_if.Grc = 1; dp_if.Rin = 1; step();
        put_inport(32'h9);         dp_if.PCin = 1; step();
        put_inport(32'h77);        dp_if.Rin = 1; step();
        put_inport(32'h11);        dp_if.HIin = 1; step();
        put_inport(32'h22);        dp_if.LOin = 1; step();
        clear_ctl();
        dp_if.Rout = 1; dp_if.Grc = 1; dp_if.PCout = 1; #1;
        check("prio_rout_pc", {32'b0, dp_if.BusMuxOut}, 64'h5);
        clear_ctl(); #1;
        check("prio_none", {32'b0, dp_if.BusMuxOut}, 64'h0);
        dp_if.BAout = 1; #1;
        check("baout_r0", {32'b0, dp_if.BusMuxOut}, 64'h0);
        clear_ctl(); dp_if.Rout = 1; #1;
        check("rout_r0", {32'b0, dp_if.BusMuxOut}, 64'h77);
        clear_ctl(); dp_if.BAout = 1; dp_if.Grc = 1; #1;
        check("baout_r2", {32'b0, dp_if.BusMuxOut}, 64'h5);
        clear_ctl(); dp_if.HIout = 1; dp_if.LOout = 1; dp_if.PCout = 1; #1;
        check("prio_hi_lo", {32'b0, dp_if.BusMuxOut}, 64'h11);
        clear_ctl(); dp_if.LOout = 1; dp_if.PCout = 1; #1;
        check("prio_lo_pc", {32'b0, dp_if.BusMuxOut}, 64'h22);
        clear_ctl(); dp_if.PCout = 1; dp_if.MDRout = 1; #1;
        check("prio_pc_mdr", {32'b0, dp_if.BusMuxOut}, 64'h9);
        clear_ctl();

        // OutPort
        put_inport(32'hA5A5_0001); dp_if.outPortin = 1; step(); clear_ctl();
        check("outport", {32'b0, dp_if.OutPort_q}, 64'hA5A5_0001);

        // CON conditions
        foreach (con_vecs[i]) begin
            put_inport(con_vecs[i].ir); dp_if.IRin = 1; step();
            put_inport(con_vecs[i].busv); dp_if.conIn = 1; step(); clear_ctl();
            check($sformatf("con_%0d", i), {63'b0, dp_if.CON}, {63'b0, con_vecs[i].exp});
        end
        dp_if.conOut = 1; #1;
        check("con_out_bus", {32'b0, dp_if.BusMuxOut}, 64'h1);
        clear_ctl();

        // Reset mid-sequence overrides an in-flight step
        reset = 1'b1;
        dp_if.PCout = 1; dp_if.MARin = 1; dp_if.IncPC = 1; dp_if.Zin = 1; dp_if.PCin = 1;
        dp_if.conIn = 1;
        step();
        reset = 1'b0;
        clear_ctl();
        check("midreset_pc",  {32'b0, dp_if.PC_q}, 64'h0);
        check("midreset_mar", {32'b0, dp_if.MAR_q}, 64'h0);
        check("midreset_z",   dp_if.Z_q, 64'h0);
        check("midreset_con", {63'b0, dp_if.CON}, 64'h0);
        check("midreset_outport", {32'b0, dp_if.OutPort_q}, 64'h0);
        dp_if.Grc = 1; dp_if.Rout = 1; #1;
        check("midreset_gpr", {32'b0, dp_if.BusMuxOut}, 64'h0);
        clear_ctl();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
